// File: rtl/ats_cmd_collector.sv
// ats_cmd_collector: ATS instruction front-end.
// Each client channel delivers a two-beat instruction (upper beat, then lower beat).
// Completed instructions wait in a per-client holding register. A round-robin
// arbiter moves them into a shared FIFO, which feeds the ATS core through a
// valid/ready handshake.
// Optional build macro: OPCODE_FILTER_EN. When it is defined, completed
// instructions that carry reserved opcode 3'b100 are discarded and counted as drops.
module ats_cmd_collector #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned HALF_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CW          = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req,
  input  logic [NUM_CLIENTS*HALF_W-1:0] ctrl,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*HALF_W-1:0]           out_instr,
  output logic [CW-1:0]                 out_client,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [NUM_CLIENTS-1:0]        hold_full,
  output logic [NUM_CLIENTS-1:0]        drop_pulse,
  output logic [7:0]                    drop_count
);

  localparam int unsigned IW   = 2 * HALF_W;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned DSW  = 9;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_HALF2 = 1'b1;
  localparam logic [2:0] OP_NONE  = 3'b000;
`ifdef OPCODE_FILTER_EN
  localparam logic [2:0] OP_RSVD  = 3'b100;
`endif

  // Per-client capture state and storage
  logic [0:0]             state_q [NUM_CLIENTS];
  logic [0:0]             state_d [NUM_CLIENTS];
  logic [HALF_W-1:0]      beat_c  [NUM_CLIENTS];
  logic [HALF_W-1:0]      upper_q [NUM_CLIENTS];
  logic [IW-1:0]          hold_q  [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] start_c;
  logic [NUM_CLIENTS-1:0] complete_c;
  logic [NUM_CLIENTS-1:0] rsvd_c;
  logic [NUM_CLIENTS-1:0] accept_c;
  logic [NUM_CLIENTS-1:0] drop_c;

  // Arbiter
  logic [CW-1:0]          rr_ptr;
  logic [CW-1:0]          rr_next_c;
  logic [NUM_CLIENTS-1:0] grant_c;
  logic                   grant_any_c;
  logic [CW-1:0]          grant_idx_c;
  int                     arb_idx;
  int                     arb_dist;

  // Drop accounting
  logic [DSW-1:0]         drop_sum_c;
  logic [DSW-1:0]         drop_total_c;
  logic [7:0]             drop_count_d;

  // FIFO
  logic [IW-1:0]          mem_instr  [FIFO_DEPTH];
  logic [CW-1:0]          mem_client [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          rd_ptr_d;
  logic [CNTW-1:0]        count_d;
  logic [CNTW-1:0]        remain_c;
  logic                   push_c;
  logic                   pop_c;
  logic [IW-1:0]          push_instr_c;
  logic [IW-1:0]          head_instr_c;
  logic [CW-1:0]          head_client_c;

  // Split the shared ctrl bus into per-client beats
  always_comb begin
    for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
      beat_c[c] = ctrl[c*HALF_W +: HALF_W];
    end
  end

  // Capture FSM next state: IDLE latches the upper beat, HALF2 completes unconditionally
  always_comb begin
    start_c    = '0;
    complete_c = '0;
    for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        ST_IDLE: begin
          if (req && (beat_c[c][HALF_W-1 -: 3] != OP_NONE)) begin
            state_d[c] = ST_HALF2;
            start_c[c] = 1'b1;
          end
        end
        ST_HALF2: begin
          state_d[c]    = ST_IDLE;
          complete_c[c] = 1'b1;
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

  // Reserved-opcode detection on the instruction that completes this cycle
  always_comb begin
    rsvd_c = '0;
`ifdef OPCODE_FILTER_EN
    for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
      rsvd_c[c] = (upper_q[c][HALF_W-1 -: 3] == OP_RSVD);
    end
`endif
  end

  // Round-robin grant: the full register nearest after rr_ptr wins, if the FIFO has room
  always_comb begin
    arb_dist    = int'(NUM_CLIENTS);
    arb_idx     = 0;
    grant_any_c = 1'b0;
    if (fifo_count < CNTW'(FIFO_DEPTH)) begin
      for (int j = 0; j < int'(NUM_CLIENTS); j++) begin
        if (hold_full[j] &&
            (((j + int'(NUM_CLIENTS) - int'(rr_ptr)) % int'(NUM_CLIENTS)) < arb_dist)) begin
          arb_dist    = (j + int'(NUM_CLIENTS) - int'(rr_ptr)) % int'(NUM_CLIENTS);
          arb_idx     = j;
          grant_any_c = 1'b1;
        end
      end
    end
    grant_c = '0;
    for (int j = 0; j < int'(NUM_CLIENTS); j++) begin
      grant_c[j] = grant_any_c && (arb_idx == j);
    end
    grant_idx_c = CW'(arb_idx);
    rr_next_c   = CW'((arb_idx + 1) % int'(NUM_CLIENTS));
  end

  // Completion outcome: store into the holding register (possibly refilled on its grant edge) or drop
  always_comb begin
    for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
      accept_c[c] = complete_c[c] && !rsvd_c[c] && (!hold_full[c] || grant_c[c]);
      drop_c[c]   = complete_c[c] && (rsvd_c[c] || (hold_full[c] && !grant_c[c]));
    end
  end

  // Saturating drop counter: several clients can drop in the same cycle
  always_comb begin
    drop_sum_c = '0;
    for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
      drop_sum_c = drop_sum_c + DSW'(drop_c[c]);
    end
    drop_total_c = DSW'(drop_count) + drop_sum_c;
    drop_count_d = (drop_total_c > DSW'(255)) ? 8'hFF : drop_total_c[7:0];
  end

  // Per-client state, holding registers and drop reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
        state_q[c] <= ST_IDLE;
        upper_q[c] <= '0;
        hold_q[c]  <= '0;
      end
      hold_full  <= '0;
      drop_pulse <= '0;
      drop_count <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int c = 0; c < int'(NUM_CLIENTS); c++) begin
        state_q[c] <= state_d[c];
        if (start_c[c]) begin
          upper_q[c] <= beat_c[c];
        end
        if (accept_c[c]) begin
          hold_q[c]    <= {upper_q[c], beat_c[c]};
          hold_full[c] <= 1'b1;
        end else if (grant_c[c]) begin
          hold_full[c] <= 1'b0;
        end
      end
      drop_pulse <= drop_c;
      drop_count <= drop_count_d;
      if (grant_any_c) begin
        rr_ptr <= rr_next_c;
      end
    end
  end

  // FIFO control: a push is blocked when full even if a pop happens in the same cycle
  always_comb begin
    push_c       = grant_any_c;
    pop_c        = out_valid && out_ready;
    push_instr_c = hold_q[grant_idx_c];
    rd_ptr_d     = pop_c ? (rd_ptr + AW'(1)) : rd_ptr;
    count_d      = fifo_count;
    if (push_c && !pop_c) begin
      count_d = fifo_count + CNTW'(1);
    end else if (!push_c && pop_c) begin
      count_d = fifo_count - CNTW'(1);
    end
    remain_c = fifo_count - CNTW'(pop_c);
    if (remain_c == '0) begin
      head_instr_c  = push_instr_c;
      head_client_c = grant_idx_c;
    end else begin
      head_instr_c  = mem_instr[rd_ptr_d];
      head_client_c = mem_client[rd_ptr_d];
    end
  end

  // FIFO storage; contents need no reset because the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_instr[wr_ptr]  <= push_instr_c;
      mem_client[wr_ptr] <= grant_idx_c;
    end
  end

  // FIFO pointers, occupancy and the registered head outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_client <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_ptr_d;
      fifo_count <= count_d;
      out_valid  <= (count_d != '0);
      if (count_d != '0) begin
        out_instr  <= head_instr_c;
        out_client <= head_client_c;
      end
    end
  end

endmodule

// File: tb/tb_ats_cmd_collector.sv
// Bench for ats_cmd_collector. It drives directed and random stimulus and checks
// the outputs every cycle against a queue-based reference model.
module tb_ats_cmd_collector;

  localparam int NC    = 4;
  localparam int HW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [NC*HW-1:0] ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [2*HW-1:0] out_instr;
  logic [1:0]    out_client;
  logic [2:0]    fifo_count;
  logic [NC-1:0] hold_full;
  logic [NC-1:0] drop_pulse;
  logic [7:0]    drop_count;

  int total = 0;
  int bad   = 0;

  ats_cmd_collector #(.NUM_CLIENTS(NC), .HALF_W(HW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .ctrl(ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_client(out_client), .fifo_count(fifo_count), .hold_full(hold_full),
    .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [31:0] instr;
    int          client;
  } ent_t;

  ent_t          m_fifo[$];
  bit [NC-1:0]   m_phase;
  logic [15:0]   m_upper [NC];
  logic [31:0]   m_hold  [NC];
  bit [NC-1:0]   m_hfull;
  bit [NC-1:0]   m_dpulse;
  int            m_rr;
  int            m_dcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [15:0] b0, input logic [15:0] b1,
                                     input logic [15:0] b2, input logic [15:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  // One clock of the specified behaviour, at transaction level
  task automatic model_step(input bit r, input bit q, input logic [NC*HW-1:0] cv, input bit rdy);
    int grant;
    ent_t e;
    logic [15:0] beat;
    bit filt;
    if (r) begin
      m_fifo.delete();
      m_phase  = '0;
      m_hfull  = '0;
      m_dpulse = '0;
      m_rr     = 0;
      m_dcnt   = 0;
      return;
    end
    grant = -1;
    if (m_fifo.size() < DEPTH) begin
      for (int i = 0; i < NC; i++) begin
        int cc;
        cc = (m_rr + i) % NC;
        if (grant < 0 && m_hfull[cc]) grant = cc;
      end
    end
    if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
    if (grant >= 0) begin
      e.instr  = m_hold[grant];
      e.client = grant;
      m_fifo.push_back(e);
      m_hfull[grant] = 1'b0;
      m_rr = (grant + 1) % NC;
    end
    m_dpulse = '0;
    for (int k = 0; k < NC; k++) begin
      beat = cv[k*HW +: HW];
      if (m_phase[k]) begin
        filt = 1'b0;
`ifdef OPCODE_FILTER_EN
        filt = (m_upper[k][15:13] == 3'b100);
`endif
        if (filt || m_hfull[k]) begin
          m_dpulse[k] = 1'b1;
          if (m_dcnt < 255) m_dcnt++;
        end else begin
          m_hold[k]  = {m_upper[k], beat};
          m_hfull[k] = 1'b1;
        end
        m_phase[k] = 1'b0;
      end else if (q && beat[15:13] != 3'b000) begin
        m_phase[k] = 1'b1;
        m_upper[k] = beat;
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_fifo.size() != 0));
    chk("fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
    if (m_fifo.size() > 0) begin
      chk("out_instr", 64'(out_instr), 64'(m_fifo[0].instr));
      chk("out_client", 64'(out_client), 64'(m_fifo[0].client));
    end
    chk("hold_full", 64'(hold_full), 64'(m_hfull));
    chk("drop_pulse", 64'(drop_pulse), 64'(m_dpulse));
    chk("drop_count", 64'(drop_count), 64'(m_dcnt));
  endtask

  // Apply one cycle of inputs, advance the model, then check the registered outputs
  task automatic step(input bit r, input bit q, input logic [NC*HW-1:0] cv, input bit rdy);
    reset     = r;
    req       = q;
    ctrl      = cv;
    out_ready = rdy;
    @(posedge clk);
    model_step(r, q, cv, rdy);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; ctrl = '0; out_ready = 1'b0;

    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_hold", 64'(hold_full), 64'd0);

    // Aligned request: entries visible at T+3, two entries pile up under backpressure
    step(1'b0, 1'b1, mk(16'h2000, 16'h3280, 16'h0000, 16'h0000), 1'b0);
    chk("lat_t1", 64'(out_valid), 64'd0);
    step(1'b0, 1'b0, mk(16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    chk("lat_t2", 64'(out_valid), 64'd0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("lat_t3", 64'(out_valid), 64'd1);
    chk("lat_instr", 64'(out_instr), 64'h2000_0000);
    chk("lat_client", 64'(out_client), 64'd0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("aligned_peak", 64'(fifo_count), 64'd2);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);

    // Staggered request: client1 starts while client0 is in its second beat
    step(1'b0, 1'b1, mk(16'h2600, 16'h0000, 16'h0000, 16'h0000), 1'b1);
    step(1'b0, 1'b1, mk(16'h0000, 16'h2840, 16'h0000, 16'h0000), 1'b1);
    step(1'b0, 1'b0, mk(16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b1);
    repeat (5) step(1'b0, 1'b0, '0, 1'b1);
    chk("stagger_drops", 64'(drop_count), 64'd0);

    // Backpressure: six back-to-back instructions from client0, the sixth drops
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, mk(16'h6000 | 16'(i), 16'h0, 16'h0, 16'h0), 1'b0);
      step(1'b0, 1'b1, mk(16'(i * 7 + 1), 16'h0, 16'h0, 16'h0), 1'b0);
    end
    repeat (2) step(1'b0, 1'b0, '0, 1'b0);
    chk("bp_count", 64'(fifo_count), 64'd4);
    chk("bp_hold", 64'(hold_full[0]), 64'd1);
    chk("bp_drop", 64'(drop_count), 64'd1);
    repeat (10) step(1'b0, 1'b0, '0, 1'b1);

    // Fairness: every client completes every two cycles with the consumer always ready
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, mk(16'h2000 | 16'(i), 16'h4000 | 16'(i), 16'h6000 | 16'(i), 16'hE000 | 16'(i)), 1'b1);
      step(1'b0, 1'b0, {$urandom, $urandom}, 1'b1);
    end

    // Drop counter saturation under permanent backpressure
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'b1, mk(16'h2001, 16'h4002, 16'h6003, 16'hE004), 1'b0);
      step(1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
    end
    chk("drop_sat", 64'(drop_count), 64'd255);
    step(1'b1, 1'b0, '0, 1'b1);

    // Reset during the second beat discards the partial instruction
    step(1'b0, 1'b1, mk(16'h2ABC, 16'h4DEF, 16'h0000, 16'h0000), 1'b1);
    step(1'b1, 1'b0, mk(16'h1111, 16'h2222, 16'h0000, 16'h0000), 1'b1);
    chk("midrst_hold", 64'(hold_full), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);
    chk("midrst_empty", 64'(fifo_count), 64'd0);

    // Reserved opcode 100 on client2
    step(1'b0, 1'b1, mk(16'h0000, 16'h0000, 16'h8000, 16'h0000), 1'b1);
    step(1'b0, 1'b0, mk(16'h0000, 16'h0000, 16'h1234, 16'h0000), 1'b1);
`ifdef OPCODE_FILTER_EN
    chk("filt_pulse", 64'(drop_pulse[2]), 64'd1);
`else
    chk("filt_hold", 64'(hold_full[2]), 64'd1);
`endif
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic: mostly-ready consumer, then a mostly-stalled one
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), {$urandom, $urandom},
           $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), {$urandom, $urandom},
           $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
